// File: rtl/johnson_counter_param.sv
// Parameterised Johnson (twisted-ring) counter with load, direction, decode, wrap and error pulses.
// Optional self-correction of illegal codes is enabled by defining JOHNSON_SELF_CORRECT_EN.
module johnson_counter_param #(
   parameter int WIDTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         en,
   input  logic                         dir,
   input  logic                         load,
   input  logic [WIDTH-1:0]             load_val,
   output logic [WIDTH-1:0]             out,
   output logic [$clog2(2*WIDTH)-1:0]   idx,
   output logic [2*WIDTH-1:0]           dec,
   output logic                         wrap,
   output logic                         err
);

   localparam int NSTATES = 2 * WIDTH;
   localparam int IDXW    = $clog2(NSTATES);

   // Code of state k: k ones filling from the MSB, then ones draining from the MSB.
   function automatic logic [WIDTH-1:0] code_of(input int k);
      logic [WIDTH-1:0] c;
      c = '0;
      for (int b = 0; b < WIDTH; b++) begin
         if (k <= WIDTH) c[b] = (b >= WIDTH - k);
         else            c[b] = (b < NSTATES - k);
      end
      return c;
   endfunction

   function automatic logic is_legal(input logic [WIDTH-1:0] v);
      logic hit;
      hit = 1'b0;
      for (int k = 0; k < NSTATES; k++) begin
         if (v == code_of(k)) hit = 1'b1;
      end
      return hit;
   endfunction

   logic [WIDTH-1:0] fwd_code;
   logic [WIDTH-1:0] rev_code;
   logic             out_legal;
   logic [WIDTH-1:0] next_out;
   logic             next_wrap;
   logic             next_err;
   logic             wrap_q;

   assign fwd_code = {~out[0], out[WIDTH-1:1]};
   assign rev_code = {out[WIDTH-2:0], ~out[WIDTH-1]};

   // Decode: illegal codes match no state, leaving idx=0 and dec empty.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no latch is inferred.
      idx       = '0;
      dec       = '0;
      out_legal = 1'b0;
      for (int k = 0; k < NSTATES; k++) begin
         if (out == code_of(k)) begin
            idx       = IDXW'(k);
            dec[k]    = 1'b1;
            out_legal = 1'b1;
         end
      end
   end

   always_comb begin
      next_out  = out;
      next_wrap = 1'b0;
      next_err  = 1'b0;
`ifdef JOHNSON_SELF_CORRECT_EN
      if (load) begin
         if (is_legal(load_val)) begin
            next_out = load_val;
         end else begin
            next_out = '0;
            next_err = 1'b1;
         end
      end else if (!out_legal) begin
         next_out = '0;
         next_err = 1'b1;
      end else if (en) begin
`else
      if (load) begin
         next_out = load_val;
      end else if (en) begin
`endif
         if (dir) begin
            next_out  = rev_code;
            next_wrap = (out == code_of(0));
         end else begin
            next_out  = fwd_code;
            next_wrap = (out == code_of(NSTATES - 1));
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out    <= '0;
         wrap_q <= 1'b0;
      end else begin
         out    <= next_out;
         wrap_q <= next_wrap;
      end
   end

   assign wrap = wrap_q;

`ifdef JOHNSON_SELF_CORRECT_EN
   logic err_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) err_q <= 1'b0;
      else     err_q <= next_err;
   end

   assign err = err_q;
`else
   // Without self-correction illegal codes simply circulate and never flag.
   logic unused_err;
   assign unused_err = next_err ^ is_legal(load_val) ^ out_legal;
   assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_johnson_counter_param.sv
// Directed table-driven bench for johnson_counter_param (WIDTH=4 and WIDTH=8 instances).
// Expected values follow the JOHNSON_SELF_CORRECT_EN build setting.
module tb_johnson_counter_param;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, en, dir, load;
   logic [3:0] load_val, out;
   logic [2:0] idx;
   logic [7:0] dec;
   logic       wrap, err;

   logic        rst8, en8, dir8, load8;
   logic [7:0]  load_val8, out8;
   logic [3:0]  idx8;
   logic [15:0] dec8;
   logic        wrap8, err8;

   johnson_counter_param #(.WIDTH(4)) dut4 (
      .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load), .load_val(load_val),
      .out(out), .idx(idx), .dec(dec), .wrap(wrap), .err(err)
   );

   johnson_counter_param #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst8), .en(en8), .dir(dir8), .load(load8), .load_val(load_val8),
      .out(out8), .idx(idx8), .dec(dec8), .wrap(wrap8), .err(err8)
   );

   int passed = 0;
   int total  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   typedef struct {
      string      name;
      logic       en, dir, load;
      logic [3:0] lv;
      logic [3:0] o;
      int         i;
      logic [7:0] d;
      logic       w, e;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input string name, input logic e_n, input logic d_r, input logic ld,
                      input logic [3:0] lv, input logic [3:0] o, input int i,
                      input logic [7:0] d, input logic w, input logic e);
      vec_t v;
      v.name = name; v.en = e_n; v.dir = d_r; v.load = ld; v.lv = lv;
      v.o = o; v.i = i; v.d = d; v.w = w; v.e = e;
      vecs.push_back(v);
   endtask

   task automatic check4(input string name, input logic [3:0] o, input int i,
                         input logic [7:0] d, input logic w, input logic e);
      check({name, ".out"},  32'(out),  32'(o));
      check({name, ".idx"},  32'(idx),  32'(i));
      check({name, ".dec"},  32'(dec),  32'(d));
      check({name, ".wrap"}, 32'(wrap), 32'(w));
      check({name, ".err"},  32'(err),  32'(e));
   endtask

   initial begin
      rst = 1'b0; en = 1'b0; dir = 1'b0; load = 1'b0; load_val = '0;
      rst8 = 1'b0; en8 = 1'b0; dir8 = 1'b0; load8 = 1'b0; load_val8 = '0;
      #1 rst = 1'b1; rst8 = 1'b1;
      #2;
      check4("reset_async", 4'b0000, 0, 8'h01, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1 check4("reset_held", 4'b0000, 0, 8'h01, 1'b0, 1'b0);
      check("reset8.out", 32'(out8), 32'h0);
      check("reset8.dec", 32'(dec8), 32'h1);
      @(negedge clk) rst = 1'b0; rst8 = 1'b0;

      // Forward run of 9 steps, then direction changes, loads and illegal codes.
      add("fwd1", 1, 0, 0, 4'h0, 4'b1000, 1, 8'h02, 0, 0);
      add("fwd2", 1, 0, 0, 4'h0, 4'b1100, 2, 8'h04, 0, 0);
      add("fwd3", 1, 0, 0, 4'h0, 4'b1110, 3, 8'h08, 0, 0);
      add("fwd4", 1, 0, 0, 4'h0, 4'b1111, 4, 8'h10, 0, 0);
      add("fwd5", 1, 0, 0, 4'h0, 4'b0111, 5, 8'h20, 0, 0);
      add("fwd6", 1, 0, 0, 4'h0, 4'b0011, 6, 8'h40, 0, 0);
      add("fwd7", 1, 0, 0, 4'h0, 4'b0001, 7, 8'h80, 0, 0);
      add("fwd8", 1, 0, 0, 4'h0, 4'b0000, 0, 8'h01, 1, 0);
      add("fwd9", 1, 0, 0, 4'h0, 4'b1000, 1, 8'h02, 0, 0);
      add("hold", 0, 1, 0, 4'h0, 4'b1000, 1, 8'h02, 0, 0);
      add("rev1", 1, 1, 0, 4'h0, 4'b0000, 0, 8'h01, 0, 0);
      add("rev2", 1, 1, 0, 4'h0, 4'b0001, 7, 8'h80, 1, 0);
      add("rev3", 1, 1, 0, 4'h0, 4'b0011, 6, 8'h40, 0, 0);
      add("turn1", 1, 0, 0, 4'h0, 4'b0001, 7, 8'h80, 0, 0);
      add("turn2", 1, 0, 0, 4'h0, 4'b0000, 0, 8'h01, 1, 0);
      add("ld1110", 1, 1, 1, 4'b1110, 4'b1110, 3, 8'h08, 0, 0);
      add("ld0001", 0, 0, 1, 4'b0001, 4'b0001, 7, 8'h80, 0, 0);
      add("ld0000", 1, 0, 1, 4'b0000, 4'b0000, 0, 8'h01, 0, 0);
`ifdef JOHNSON_SELF_CORRECT_EN
      add("ld1010", 0, 0, 1, 4'b1010, 4'b0000, 0, 8'h01, 0, 1);
      add("ill_fwd", 1, 0, 0, 4'h0, 4'b1000, 1, 8'h02, 0, 0);
      add("ill_hold", 0, 0, 0, 4'h0, 4'b1000, 1, 8'h02, 0, 0);
      add("ill_rev", 1, 1, 0, 4'h0, 4'b0000, 0, 8'h01, 0, 0);
`else
      add("ld1010", 0, 0, 1, 4'b1010, 4'b1010, 0, 8'h00, 0, 0);
      add("ill_fwd", 1, 0, 0, 4'h0, 4'b1101, 0, 8'h00, 0, 0);
      add("ill_hold", 0, 0, 0, 4'h0, 4'b1101, 0, 8'h00, 0, 0);
      add("ill_rev", 1, 1, 0, 4'h0, 4'b1010, 0, 8'h00, 0, 0);
`endif

      foreach (vecs[n]) begin
         @(negedge clk);
         en = vecs[n].en; dir = vecs[n].dir; load = vecs[n].load; load_val = vecs[n].lv;
         @(posedge clk);
         #1 check4(vecs[n].name, vecs[n].o, vecs[n].i, vecs[n].d, vecs[n].w, vecs[n].e);
      end

      // Reset asserted mid-cycle at 1111 discards the count immediately.
      @(negedge clk) en = 1'b0; load = 1'b1; load_val = 4'b1111;
      @(posedge clk) #1 check4("pre_rst", 4'b1111, 4, 8'h10, 0, 0);
      @(negedge clk) load = 1'b0; en = 1'b1; dir = 1'b0;
      #1 rst = 1'b1;
      #1 check4("mid_rst", 4'b0000, 0, 8'h01, 0, 0);
      @(posedge clk) #1 check4("rst_en", 4'b0000, 0, 8'h01, 0, 0);
      @(negedge clk) rst = 1'b0;
      @(posedge clk) #1 check4("post_rst", 4'b1000, 1, 8'h02, 0, 0);
      @(negedge clk) en = 1'b0;

      // WIDTH=8: 16 forward steps return to zero with exactly one wrap.
      begin
         logic [7:0] e8;
         int wraps;
         e8 = '0;
         wraps = 0;
         for (int k = 1; k <= 16; k++) begin
            @(negedge clk) en8 = 1'b1; dir8 = 1'b0;
            @(posedge clk);
            #1;
            e8 = {~e8[0], e8[7:1]};
            if (wrap8 === 1'b1) wraps++;
            check($sformatf("w8_out%0d", k), 32'(out8), 32'(e8));
            check($sformatf("w8_idx%0d", k), 32'(idx8), 32'(k % 16));
            check($sformatf("w8_dec%0d", k), 32'(dec8), 32'(16'(1) << (k % 16)));
            check($sformatf("w8_wrap%0d", k), 32'(wrap8), 32'(k == 16));
            check($sformatf("w8_err%0d", k), 32'(err8), 32'(0));
         end
         check("w8_final", 32'(out8), 32'h0);
         check("w8_wraps", 32'(wraps), 32'd1);
         @(negedge clk) en8 = 1'b0;
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
